// File: rtl/clk_div_bank.sv
// +--------------------------------------------------------------------------+
// | clk_div_bank                                                             |
// | Bank of runtime-configurable clock dividers with a sequenced lock flag.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module clk_div_bank #(
  parameter int NUM_CLKS    = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  localparam int SEL_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_wr,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_high,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic [NUM_CLKS-1:0] outclk,
  output logic                locked,
  output logic                cfg_err
);

  localparam int LK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [DIV_W-1:0] c_one      = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_two      = DIV_W'(2);
  localparam logic [DIV_W-1:0] c_def_div  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] c_def_high = DIV_W'(DEF_DIV / 2);
  localparam logic [SEL_W:0]   c_num_clks = (SEL_W + 1)'(NUM_CLKS);
  localparam logic [LK_W-1:0]  c_lk_one   = LK_W'(1);
  localparam logic [LK_W-1:0]  c_lk_last  = LK_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_SETTLE = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LK_W-1:0]     r_lock_cnt;
  logic                r_locked;
  logic                r_cfg_err;
  logic [NUM_CLKS-1:0] w_out;

  logic                w_wr_ok;
  logic                w_run;
  logic                w_keep;
  logic [DIV_W-1:0]    w_div_s;
  logic [DIV_W-1:0]    w_high_s;
  logic [DIV_W-1:0]    w_phase_s;

  // Write data is clamped into a legal (div, high, phase) triple before storage.
  assign w_wr_ok   = cfg_wr && ({1'b0, cfg_sel} < c_num_clks);
  assign w_div_s   = (cfg_div < c_two) ? c_two : cfg_div;
  assign w_high_s  = (cfg_high == '0)      ? c_one :
                     (cfg_high >= w_div_s) ? (w_div_s - c_one) : cfg_high;
  assign w_phase_s = (cfg_phase >= w_div_s) ? '0 : cfg_phase;

  assign w_run  = (r_state == S_SETTLE) || (r_state == S_LOCKED);
  assign w_keep = w_run && ((w_state_nxt == S_SETTLE) || (w_state_nxt == S_LOCKED));

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_SYNC;
        S_SYNC:   w_state_nxt = S_SETTLE;
        S_SETTLE: begin
          if (w_wr_ok)                       w_state_nxt = S_SYNC;
          else if (r_lock_cnt == c_lk_last)  w_state_nxt = S_LOCKED;
        end
        S_LOCKED: if (w_wr_ok) w_state_nxt = S_SYNC;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_lock_cnt <= (r_state == S_SETTLE) ? (r_lock_cnt + c_lk_one) : '0;
      r_locked   <= (w_state_nxt == S_LOCKED);
      r_cfg_err  <= cfg_wr && !w_wr_ok;
    end
  end

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
    logic             w_hit;
    logic [DIV_W-1:0] w_nx_div, w_nx_high, w_nx_phase;
    logic [DIV_W-1:0] r_sh_div, r_sh_high, r_sh_phase;
    logic [DIV_W-1:0] r_div, r_high, r_cnt;
    logic             r_out;

    assign w_hit      = w_wr_ok && (cfg_sel == SEL_W'(i));
    // A write landing in the SYNC cycle itself is folded into the load.
    assign w_nx_div   = w_hit ? w_div_s   : r_sh_div;
    assign w_nx_high  = w_hit ? w_high_s  : r_sh_high;
    assign w_nx_phase = w_hit ? w_phase_s : r_sh_phase;

    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        r_sh_div   <= c_def_div;
        r_sh_high  <= c_def_high;
        r_sh_phase <= '0;
        r_div      <= c_def_div;
        r_high     <= c_def_high;
        r_cnt      <= '0;
        r_out      <= 1'b0;
      end else begin
        r_sh_div   <= w_nx_div;
        r_sh_high  <= w_nx_high;
        r_sh_phase <= w_nx_phase;
        if (r_state == S_SYNC) begin
          r_div  <= w_nx_div;
          r_high <= w_nx_high;
          r_cnt  <= (w_nx_phase == '0) ? '0 : (w_nx_div - w_nx_phase);
        end else if (w_run) begin
          r_cnt  <= (r_cnt == (r_div - c_one)) ? '0 : (r_cnt + c_one);
        end
        r_out <= w_keep && (r_cnt < r_high);
      end
    end

    assign w_out[i] = r_out;
  end

  assign outclk  = w_out;
  assign locked  = r_locked;
  assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// +--------------------------------------------------------------------------+
// | tb_clk_div_bank                                                          |
// | Directed scoreboard bench for clk_div_bank (three channels).             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_clk_div_bank;

  logic       refclk;
  logic       rst;
  logic       en;
  logic       cfg_wr;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic [7:0] cfg_phase;
  logic [2:0] outclk;
  logic       locked;
  logic       cfg_err;

  clk_div_bank #(
    .NUM_CLKS    (3),
    .DIV_W       (8),
    .LOCK_CYCLES (16),
    .DEF_DIV     (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .en        (en),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .locked    (locked),
    .cfg_err   (cfg_err)
  );

  typedef struct {
    int         cyc;
    logic [2:0] out;
    logic       lk;
    logic       err;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   errors;
  event sample_ev;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at the current cycle and compares.
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(negedge refclk or sample_ev);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.nm, e.cyc, cyc);
        end else if (outclk !== e.out || locked !== e.lk || cfg_err !== e.err) begin
          errors++;
          $display("FAIL %s @cyc %0d: got outclk=%b locked=%b cfg_err=%b, expected outclk=%b locked=%b cfg_err=%b",
                   e.nm, cyc, outclk, locked, cfg_err, e.out, e.lk, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic push_exp(input int c, input logic [2:0] o, input logic l, input logic e, input string nm);
    exp_t x;
    x.cyc = c; x.out = o; x.lk = l; x.err = e; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] d, input logic [7:0] h, input logic [7:0] p);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_div = d; cfg_high = h; cfg_phase = p;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  // Defaults (div 2, high 1): en sampled at a+1 -> SYNC, first SETTLE at a+2,
  // toggling 111/000 from a+3, locked from a+18.
  task automatic exp_default(input int a, input string nm);
    for (int k = 1; k <= 19; k++)
      push_exp(a + k, (k >= 3 && (k % 2) == 1) ? 3'b111 : 3'b000, k >= 18, 1'b0, nm);
  endtask

  // ch0 div4 high1 ph0 -> 1000; ch1 div4 high2 ph1 -> 0110; ch2 default 1010.
  task automatic exp_mix(input int c, input string nm);
    for (int k = 1; k <= 18; k++) begin
      int j;
      logic [2:0] o;
      j = (k - 2) % 4;
      o = (k < 2) ? 3'b000 : {(k % 2) == 0, (j == 1 || j == 2), j == 0};
      push_exp(c + k, o, k >= 17, 1'b0, nm);
    end
  endtask

  // ch0 div2 high1 (sanitised), ch1 div6 high5 (sanitised), ch2 default.
  task automatic exp_san(input int e, input int k0, input int k1, input int errk, input string nm);
    for (int k = k0; k <= k1; k++) begin
      logic [2:0] o;
      o = (k < 2) ? 3'b000 : {(k % 2) == 0, ((k - 2) % 6) < 5, (k % 2) == 0};
      push_exp(e + k, o, k >= 17, k == errk, nm);
    end
  endtask

  initial begin
    int base, a, b, d, f, g, h, r;
    rst = 1'b0; en = 1'b0; cfg_wr = 1'b0;
    cfg_sel = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;

    tick(1);
    base = cyc;
    push_exp(base + 1, 3'b000, 1'b0, 1'b0, "reset");
    push_exp(base + 2, 3'b000, 1'b0, 1'b0, "reset");
    tick(2);
    rst = 1'b1;
    push_exp(cyc + 1, 3'b000, 1'b0, 1'b0, "idle_no_en");
    tick(1);

    // Boot with defaults
    en = 1'b1;
    a = cyc;
    exp_default(a, "boot");
    tick(19);

    // Reconfigure ch0 then ch1 from LOCKED; second write resyncs again
    b = cyc;
    for (int k = 1; k <= 3; k++) push_exp(b + k, 3'b000, 1'b0, 1'b0, "resync");
    exp_mix(b + 3, "mix");
    cfg_write(2'd0, 8'd4, 8'd1, 8'd0);
    tick(1);
    cfg_write(2'd1, 8'd4, 8'd2, 8'd1);
    tick(18);

    // Sanitising writes
    d = cyc;
    for (int k = 1; k <= 3; k++) push_exp(d + k, 3'b000, 1'b0, 1'b0, "san_resync");
    exp_san(d + 3, 1, 18, -1, "sanitise");
    cfg_write(2'd0, 8'd1, 8'd0, 8'd5);
    tick(1);
    cfg_write(2'd1, 8'd6, 8'd9, 8'd0);
    tick(18);

    // Out-of-range channel: error pulse only, waveform and lock unaffected
    f = cyc;
    exp_san(f - 18, 19, 26, 19, "bad_sel");
    cfg_write(2'd3, 8'd7, 8'd3, 8'd2);
    tick(7);

    // Drop and re-raise en
    g = cyc;
    en = 1'b0;
    push_exp(g + 1, 3'b000, 1'b0, 1'b0, "en_drop");
    push_exp(g + 2, 3'b000, 1'b0, 1'b0, "en_drop");
    tick(2);
    en = 1'b1;
    h = cyc + 1;
    exp_san(h, 0, 6, -1, "en_rerun");
    tick(7);

    // Asynchronous reset between edges while mid-SETTLE
    r = cyc;
    #2;
    rst = 1'b0;
    #1;
    push_exp(r, 3'b000, 1'b0, 1'b0, "async_rst");
    ->sample_ev;
    push_exp(r + 1, 3'b000, 1'b0, 1'b0, "in_rst");
    push_exp(r + 2, 3'b000, 1'b0, 1'b0, "in_rst");
    exp_default(r + 2, "post_rst");
    tick(2);
    rst = 1'b1;
    tick(19);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never sampled, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
